// File: rtl/seq_mult_pkg.sv
// -----------------------------------------------------------------------------
// seq_mult_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   state_e    - controller states (IDLE / CALC / DONE)
//   cnt_width  - width of the iteration counter for a given operand width,
//                i.e. $clog2(WIDTH+1) so the counter can hold the value WIDTH
// -----------------------------------------------------------------------------
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration-counter width for an operand width of `width` bits.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

endpackage

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Radix-2 shift-and-add multiplier taking exactly WIDTH iterations per product.
// Operands are accepted with a valid/ready handshake; the product is held in a
// register and presented with a valid/ready handshake.
//
// Parameters
//   WIDTH     operand width (4..32)
//   SIGNED_EN 1: two's-complement operands/product, 0: unsigned
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands valid            in_ready  block can accept operands
//   a, b       multiplicand / multiplier
//   out_valid  product valid             out_ready consumer accepts product
//   product    2*WIDTH-bit result, held until the next product completes
//   busy       high while an operation is in progress (CALC or DONE)
//   acc        (only with SEQ_MULT_ACCUM_EN) sampled at accept; when 1 the new
//              product is added (mod 2^(2*WIDTH)) to the previous product
//
// Build option
//   SEQ_MULT_ACCUM_EN  enables the accumulate port and adder
// -----------------------------------------------------------------------------
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_ACCUM_EN
  input  logic                 acc,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PW    = 2 * WIDTH + 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH:0]       mcand_q, mcand_d;   // multiplicand magnitude
  logic [PW-1:0]        part_q, part_d;     // {upper accumulator, multiplier}
  logic                 sign_q, sign_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
`ifdef SEQ_MULT_ACCUM_EN
  logic                 acc_q, acc_d;
`endif

  logic [WIDTH:0]       a_mag, b_mag;
  logic [WIDTH:0]       sum;
  logic [PW-1:0]        shifted;
  logic [2*WIDTH-1:0]   result;

  // Magnitude of an operand, one bit wider so the most-negative value
  // (e.g. 0x8000 at WIDTH=16) is represented exactly.
  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
    if (SIGNED_EN && v[WIDTH-1]) begin
      return -{1'b1, v};
    end
    return {1'b0, v};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    part_d  = part_q;
    sign_d  = sign_q;
    prod_d  = prod_q;
`ifdef SEQ_MULT_ACCUM_EN
    acc_d   = acc_q;
`endif

    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);

    a_mag = magnitude(a);
    b_mag = magnitude(b);

    // One iteration: conditionally add the multiplicand into the upper half,
    // then shift the whole partial register right by one.
    sum     = part_q[PW-1:WIDTH] + (part_q[0] ? mcand_q : '0);
    shifted = {sum, part_q[WIDTH-1:0]} >> 1;

    result = sign_q ? -shifted[2*WIDTH-1:0] : shifted[2*WIDTH-1:0];
`ifdef SEQ_MULT_ACCUM_EN
    if (acc_q) begin
      result = result + prod_q;
    end
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = a_mag;
          part_d  = {{WIDTH{1'b0}}, b_mag};
          cnt_d   = '0;
          sign_d  = SIGNED_EN ? (a[WIDTH-1] ^ b[WIDTH-1]) : 1'b0;
`ifdef SEQ_MULT_ACCUM_EN
          acc_d   = acc;
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        part_d = shifted;
        cnt_d  = cnt_q + CNT_W'(1);
        // Last iteration: sign correction (and accumulation) happen on the
        // same edge that enters DONE, so the product never changes mid-CALC.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          prod_d  = result;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      part_q  <= '0;
      sign_q  <= 1'b0;
      prod_q  <= '0;
`ifdef SEQ_MULT_ACCUM_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      part_q  <= part_d;
      sign_q  <= sign_d;
      prod_q  <= prod_d;
`ifdef SEQ_MULT_ACCUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign product = prod_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
// Two DUTs at WIDTH=16: index 0 unsigned, index 1 signed. A cycle-level model
// (cycles since accept, pending result, held product) is compared with both
// DUTs on every falling edge; directed operations pin the model with literal
// expected products and latency, then a randomized phase stresses handshakes,
// stalls and reset pulses.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

  localparam int W = 16;
`ifdef SEQ_MULT_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid_s [2];
  logic        in_ready_s [2];
  logic [15:0] a_s        [2];
  logic [15:0] b_s        [2];
  logic        acc_s      [2];
  logic        out_valid_s[2];
  logic        out_ready_s[2];
  logic [31:0] product_s  [2];
  logic        busy_s     [2];

  int checks = 0;
  int errors = 0;

  // Model state per DUT: t<0 idle, 1..W computing, W+1 result presented.
  int          m_t    [2];
  logic [31:0] m_prod [2];
  logic [31:0] m_pend [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .a(a_s[0]), .b(b_s[0]),
`ifdef SEQ_MULT_ACCUM_EN
    .acc(acc_s[0]),
`endif
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .product(product_s[0]), .busy(busy_s[0])
  );

  seq_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1)) s_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .a(a_s[1]), .b(b_s[1]),
`ifdef SEQ_MULT_ACCUM_EN
    .acc(acc_s[1]),
`endif
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .product(product_s[1]), .busy(busy_s[1])
  );

  // Reference arithmetic: plain integer multiply, truncated to 2*W bits.
  function automatic logic [31:0] model_mult(input bit sgn, input logic [15:0] x,
                                             input logic [15:0] y, input bit acc,
                                             input logic [31:0] prev);
    longint xi, yi, r;
    logic [31:0] res;
    if (sgn) begin
      xi = longint'($signed(x));
      yi = longint'($signed(y));
    end else begin
      xi = longint'(x);
      yi = longint'(y);
    end
    r   = xi * yi;
    res = r[31:0];
    if (ACC_EN && acc) res = res + prev;
    return res;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin
    logic        eir, ebusy, eov;
    logic [31:0] ep;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        eir = 1'b1; ebusy = 1'b0; eov = 1'b0; ep = 32'h0;
      end else if (m_t[k] < 0) begin
        eir = 1'b1; ebusy = 1'b0; eov = 1'b0; ep = m_prod[k];
      end else if (m_t[k] <= W) begin
        eir = 1'b0; ebusy = 1'b1; eov = 1'b0; ep = m_prod[k];
      end else begin
        eir = 1'b0; ebusy = 1'b1; eov = 1'b1; ep = m_pend[k];
      end
      checks++;
      if ({in_ready_s[k], busy_s[k], out_valid_s[k], product_s[k]} !== {eir, ebusy, eov, ep}) begin
        errors++;
        $display("FAIL cycle dut%0d t=%0d: got rdy=%b busy=%b ov=%b prod=0x%08h expected rdy=%b busy=%b ov=%b prod=0x%08h",
                 k, m_t[k], in_ready_s[k], busy_s[k], out_valid_s[k], product_s[k],
                 eir, ebusy, eov, ep);
      end
      if (rst) begin
        m_t[k] = -1;
        m_prod[k] = 32'h0;
      end else if (m_t[k] < 0) begin
        if (in_valid_s[k] === 1'b1) begin
          m_pend[k] = model_mult(k == 1, a_s[k], b_s[k], acc_s[k], m_prod[k]);
          m_t[k] = 1;
        end
      end else if (m_t[k] <= W) begin
        m_t[k] = m_t[k] + 1;
      end else if (out_ready_s[k] === 1'b1) begin
        m_t[k] = -1;
        m_prod[k] = m_pend[k];
      end
    end
  end

  // Issue one operation on DUT k; hold = cycles to stall out_ready once valid.
  task automatic do_op(input int k, input logic [15:0] x, input logic [15:0] y,
                       input bit acc, input int hold,
                       output int lat, output logic [31:0] prod);
    int  n;
    bit  got;
    @(posedge clk); #1;
    a_s[k] = x; b_s[k] = y; acc_s[k] = acc;
    in_valid_s[k] = 1'b1;
    out_ready_s[k] = (hold == 0);
    n = 0; got = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (in_ready_s[k]) got = 1;
      n++;
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL accept timeout dut%0d: in_ready never seen, expected within 50 cycles", k);
    end
    @(posedge clk); #1;
    in_valid_s[k] = 1'b0;
    a_s[k] = 16'($urandom); b_s[k] = 16'($urandom); acc_s[k] = 1'($urandom);
    lat = 0; got = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid_s[k]) got = 1;
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL result timeout dut%0d: out_valid never seen, expected within 100 cycles", k);
    end
    prod = product_s[k];
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      @(posedge clk); #1;
      out_ready_s[k] = 1'b1;
      @(posedge clk); #1;
      check32("idle after release", 32'(in_ready_s[k]), 32'd1);
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] p;
    for (int k = 0; k < 2; k++) begin
      m_t[k] = -1; m_prod[k] = 32'h0; m_pend[k] = 32'h0;
      in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b1;
      a_s[k] = 16'h0; b_s[k] = 16'h0; acc_s[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check32("reset product", product_s[0], 32'h0);
    check32("reset ready/valid/busy", {29'h0, in_ready_s[0], out_valid_s[0], busy_s[0]}, 32'h4);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic unsigned product and latency.
    do_op(0, 16'd3, 16'd5, 1'b0, 0, lat, p);
    check32("3*5", p, 32'h0000000F);
    check32("latency 3*5", 32'(lat), 32'd17);
    do_op(0, 16'hFFFF, 16'hFFFF, 1'b0, 0, lat, p);
    check32("FFFF*FFFF", p, 32'hFFFE0001);
    do_op(0, 16'h0, 16'h1234, 1'b0, 0, lat, p);
    check32("0*1234", p, 32'h0);
    check32("latency zero operand", 32'(lat), 32'd17);

    // Signed products including the most-negative operand.
    do_op(1, 16'hFFFF, 16'h0002, 1'b0, 0, lat, p);
    check32("-1*2 signed", p, 32'hFFFFFFFE);
    do_op(1, 16'h8000, 16'h8000, 1'b0, 0, lat, p);
    check32("8000*8000 signed", p, 32'h40000000);
    do_op(1, 16'h8000, 16'h0001, 1'b0, 0, lat, p);
    check32("8000*1 signed", p, 32'hFFFF8000);

    // Output stall: model checks stability every cycle of the stall.
    do_op(0, 16'd100, 16'd200, 1'b0, 10, lat, p);
    check32("100*200 stalled", p, 32'd20000);

    // Reset in the middle of CALC aborts the operation.
    @(posedge clk); #1;
    a_s[0] = 16'd9; b_s[0] = 16'd9; in_valid_s[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check32("mid-calc reset product", product_s[0], 32'h0);
    check32("mid-calc reset ready/valid/busy", {29'h0, in_ready_s[0], out_valid_s[0], busy_s[0]}, 32'h4);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(0, 16'd2, 16'd7, 1'b0, 0, lat, p);
    check32("2*7 after reset", p, 32'd14);

`ifdef SEQ_MULT_ACCUM_EN
    do_op(0, 16'd2, 16'd3, 1'b0, 0, lat, p);
    check32("acc 2*3", p, 32'd6);
    do_op(0, 16'd4, 16'd5, 1'b1, 0, lat, p);
    check32("acc +4*5", p, 32'd26);
    check32("latency accumulate", 32'(lat), 32'd17);
    do_op(0, 16'hFFFF, 16'hFFFF, 1'b0, 0, lat, p);
    do_op(0, 16'hFFFF, 16'hFFFF, 1'b1, 0, lat, p);
    check32("acc wrap", p, 32'hFFFC0002);
`endif

    // Randomized traffic on both DUTs, with occasional reset pulses.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 399) == 0);
      for (int k = 0; k < 2; k++) begin
        in_valid_s[k]  = ($urandom_range(0, 2) == 0);
        out_ready_s[k] = ($urandom_range(0, 1) == 0);
        acc_s[k]       = 1'($urandom);
        case ($urandom_range(0, 5))
          0:       a_s[k] = 16'h8000;
          1:       a_s[k] = 16'hFFFF;
          2:       a_s[k] = 16'h0000;
          default: a_s[k] = 16'($urandom);
        endcase
        case ($urandom_range(0, 5))
          0:       b_s[k] = 16'h8000;
          1:       b_s[k] = 16'hFFFF;
          2:       b_s[k] = 16'h0001;
          default: b_s[k] = 16'($urandom);
        endcase
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid_s[k] = 1'b0;
      out_ready_s[k] = 1'b1;
    end
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
